// File: rtl/traffic_phase_scheduler.sv
// Two-way intersection phase sequencer with a one-second prescaler and all-red pedestrian window.
// Pedestrian service is compiled in only when PED_REQ_EN is defined.
module traffic_phase_scheduler #(
  parameter int TICK_DIV   = 10000,
  parameter int GREEN_SEC  = 15,
  parameter int YELLOW_SEC = 3,
  parameter int PED_SEC    = 10
) (
  input  logic       clk,
  input  logic       start,
  input  logic       hold,
  input  logic       ped_ns_req,
  input  logic       ped_ew_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [1:0] ped_walk,
  output logic [2:0] phase,
  output logic [3:0] remain,
  output logic       tick
);

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    AR1    = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    AR2    = 3'd5,
    PED    = 3'd6
  } state_t;

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  state_t        state;
  state_t        nxt;
  logic [2:0]    code;
  logic [CW-1:0] cnt;
  logic          tick_en;
  logic          illegal;
  logic          advance;
  logic          ped_any;
  logic          ret_ew;

  function automatic logic [3:0] dur(input state_t s);
    case (s)
      NS_GRN, EW_GRN: dur = 4'(GREEN_SEC);
      NS_YEL, EW_YEL: dur = 4'(YELLOW_SEC);
      PED:            dur = 4'(PED_SEC);
      default:        dur = 4'd1;
    endcase
  endfunction

  function automatic logic [5:0] lamps(input state_t s);
    case (s)
      NS_GRN:  lamps = {GRN, RED};
      NS_YEL:  lamps = {YEL, RED};
      EW_GRN:  lamps = {RED, GRN};
      EW_YEL:  lamps = {RED, YEL};
      default: lamps = {RED, RED};
    endcase
  endfunction

  assign code    = state;
  assign phase   = code;
  assign tick_en = (cnt == CW'(TICK_DIV - 1)) && !hold;
  // An illegal code recovers on the very next clock, independent of the tick.
  assign illegal = (code == 3'd7);
  assign advance = illegal || (tick_en && (remain == 4'd1));

`ifdef PED_REQ_EN
  logic ns_lat;
  logic ew_lat;
  logic to_ped;

  assign ped_any = ns_lat | ew_lat | ped_ns_req | ped_ew_req;
  assign to_ped  = advance && (nxt == PED);
`else
  logic unused_req;

  assign ped_any    = 1'b0;
  assign ret_ew     = 1'b0;
  assign ped_walk   = 2'b00;
  assign unused_req = ped_ns_req ^ ped_ew_req;
`endif

  always_comb begin
    nxt = NS_GRN;
    case (state)
      NS_GRN:  nxt = NS_YEL;
      NS_YEL:  nxt = AR1;
      AR1:     nxt = ped_any ? PED : EW_GRN;
      EW_GRN:  nxt = EW_YEL;
      EW_YEL:  nxt = AR2;
      AR2:     nxt = ped_any ? PED : NS_GRN;
      PED:     nxt = ret_ew ? EW_GRN : NS_GRN;
      default: nxt = NS_GRN;
    endcase
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state    <= NS_GRN;
      remain   <= 4'(GREEN_SEC);
      ns_light <= GRN;
      ew_light <= RED;
      tick     <= 1'b0;
      cnt      <= '0;
`ifdef PED_REQ_EN
      ns_lat   <= 1'b0;
      ew_lat   <= 1'b0;
      ret_ew   <= 1'b0;
      ped_walk <= 2'b00;
`endif
    end else begin
      tick <= tick_en;
      if (!hold)
        cnt <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
      if (advance) begin
        state                <= nxt;
        remain               <= dur(nxt);
        {ns_light, ew_light} <= lamps(nxt);
      end else if (tick_en) begin
        remain <= remain - 4'd1;
      end
`ifdef PED_REQ_EN
      // Entry consumes both latches and this cycle's buttons; later presses wait for the next window.
      if (to_ped) begin
        ped_walk <= {ew_lat | ped_ew_req, ns_lat | ped_ns_req};
        ns_lat   <= 1'b0;
        ew_lat   <= 1'b0;
        ret_ew   <= (state == AR1);
      end else begin
        ns_lat <= ns_lat | ped_ns_req;
        ew_lat <= ew_lat | ped_ew_req;
        if (advance)
          ped_walk <= 2'b00;
      end
`endif
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler with TICK_DIV=4; covers PED_REQ_EN on or off.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       ped_ns_req = 1'b0;
  logic       ped_ew_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [1:0] ped_walk;
  logic [2:0] phase;
  logic [3:0] remain;
  logic       tick;

  int passed = 0;
  int total = 0;
  logic [14:0] exp_q[$];

  traffic_phase_scheduler #(
    .TICK_DIV(4), .GREEN_SEC(15), .YELLOW_SEC(3), .PED_SEC(10)
  ) dut (
    .clk(clk), .start(start), .hold(hold),
    .ped_ns_req(ped_ns_req), .ped_ew_req(ped_ew_req),
    .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk),
    .phase(phase), .remain(remain), .tick(tick)
  );

  always #5 clk = ~clk;

  // Expected observable word {phase, remain, ns_light, ew_light, ped_walk} from the lamp table.
  function automatic logic [14:0] mk(input int ph, input int rem, input logic [1:0] walk);
    logic [2:0] ns, ew;
    case (ph)
      0:       begin ns = 3'b001; ew = 3'b100; end
      1:       begin ns = 3'b010; ew = 3'b100; end
      3:       begin ns = 3'b100; ew = 3'b001; end
      4:       begin ns = 3'b100; ew = 3'b010; end
      default: begin ns = 3'b100; ew = 3'b100; end
    endcase
    return {3'(ph), 4'(rem), ns, ew, walk};
  endfunction

  function automatic logic [14:0] snap();
    return {phase, remain, ns_light, ew_light, ped_walk};
  endfunction

  task automatic push(input int ph, input int hi, input int lo, input logic [1:0] walk);
    for (int r = hi; r >= lo; r--) exp_q.push_back(mk(ph, r, walk));
  endtask

  task automatic next_tick(output logic [14:0] got, output int n, output bit ok);
    ok = 0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      if (tick === 1'b1) ok = 1;
    end
    got = snap();
  endtask

  task automatic test_reset;
    start = 1'b0;
    hold = 1'b0;
    ped_ns_req = 1'b0;
    ped_ew_req = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (snap() !== mk(0, 15, 2'b00))
      $display("[TB] FAIL reset_outputs: got %h required %h", snap(), mk(0, 15, 2'b00));
    else passed++;
    total++;
    if (tick !== 1'b0) $display("[TB] FAIL reset_tick: got %b required 0", tick);
    else passed++;
    start = 1'b1;
  endtask

  task automatic test_free_run;
    logic [14:0] got, e;
    int n;
    bit ok;
    push(0, 14, 1, 2'b00); push(1, 3, 1, 2'b00); push(2, 1, 1, 2'b00);
    push(3, 15, 1, 2'b00); push(4, 3, 1, 2'b00); push(5, 1, 1, 2'b00);
    push(0, 15, 1, 2'b00);
    while (exp_q.size() > 0) begin
      next_tick(got, n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || got !== e)
        $display("[TB] FAIL free_run_tick: got %h required %h timeout=%0b", got, e, !ok);
      else passed++;
      total++;
      if (n != 4) $display("[TB] FAIL free_run_period: got %0d cycles required 4", n);
      else passed++;
    end
  endtask

  task automatic test_hold;
    logic [14:0] got, e, held;
    int n, ticks;
    bit ok, stable;
    push(1, 3, 1, 2'b00); push(2, 1, 1, 2'b00); push(3, 15, 1, 2'b00); push(4, 3, 2, 2'b00);
    while (exp_q.size() > 0) begin
      next_tick(got, n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || got !== e)
        $display("[TB] FAIL hold_approach: got %h required %h timeout=%0b", got, e, !ok);
      else passed++;
    end
    repeat (2) @(negedge clk);
    held = snap();
    hold = 1'b1;
    stable = 1;
    ticks = 0;
    repeat (100) begin
      @(negedge clk);
      if (snap() !== held) stable = 0;
      if (tick !== 1'b0) ticks++;
    end
    hold = 1'b0;
    total++;
    if (!stable) $display("[TB] FAIL hold_stable: got %h required %h", snap(), held);
    else passed++;
    total++;
    if (ticks != 0) $display("[TB] FAIL hold_no_tick: got %0d ticks required 0", ticks);
    else passed++;
    next_tick(got, n, ok);
    total++;
    if (!ok || got !== mk(4, 1, 2'b00) || n != 2)
      $display("[TB] FAIL hold_resume: got %h after %0d cycles required %h after 2",
               got, n, mk(4, 1, 2'b00));
    else passed++;
  endtask

`ifdef PED_REQ_EN
  task automatic test_ped;
    logic [14:0] got, e;
    int n;
    bit ok;
    push(5, 1, 1, 2'b00);
    while (exp_q.size() > 0) begin
      next_tick(got, n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || got !== e) $display("[TB] FAIL ped_ar2: got %h required %h", got, e);
      else passed++;
    end
    repeat (3) @(negedge clk);
    ped_ns_req = 1'b1;
    ped_ew_req = 1'b1;
    next_tick(got, n, ok);
    ped_ns_req = 1'b0;
    ped_ew_req = 1'b0;
    total++;
    if (!ok || got !== mk(6, 10, 2'b11))
      $display("[TB] FAIL ped_simultaneous: got %h required %h", got, mk(6, 10, 2'b11));
    else passed++;
    push(6, 9, 1, 2'b11); push(0, 15, 14, 2'b00);
    while (exp_q.size() > 0) begin
      next_tick(got, n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || got !== e) $display("[TB] FAIL ped_simul_walk: got %h required %h", got, e);
      else passed++;
    end
    @(negedge clk) ped_ns_req = 1'b1;
    @(negedge clk) ped_ns_req = 1'b0;
    push(0, 13, 1, 2'b00); push(1, 3, 1, 2'b00); push(2, 1, 1, 2'b00); push(6, 10, 10, 2'b01);
    while (exp_q.size() > 0) begin
      next_tick(got, n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || got !== e) $display("[TB] FAIL ped_ns_pulse: got %h required %h", got, e);
      else passed++;
    end
    @(negedge clk) ped_ew_req = 1'b1;
    @(negedge clk) ped_ew_req = 1'b0;
    push(6, 9, 1, 2'b01); push(3, 15, 1, 2'b00); push(4, 3, 1, 2'b00);
    push(5, 1, 1, 2'b00); push(6, 10, 10, 2'b10);
    while (exp_q.size() > 0) begin
      next_tick(got, n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || got !== e) $display("[TB] FAIL ped_during_walk: got %h required %h", got, e);
      else passed++;
    end
  endtask
`else
  task automatic test_ped_ignored;
    logic [14:0] got, e;
    int n;
    bit ok;
    ped_ns_req = 1'b1;
    ped_ew_req = 1'b1;
    push(5, 1, 1, 2'b00); push(0, 15, 1, 2'b00); push(1, 3, 1, 2'b00);
    push(2, 1, 1, 2'b00); push(3, 15, 13, 2'b00);
    while (exp_q.size() > 0) begin
      next_tick(got, n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || got !== e) $display("[TB] FAIL ped_ignored: got %h required %h", got, e);
      else passed++;
    end
    ped_ns_req = 1'b0;
    ped_ew_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    logic [14:0] got, e;
    int n;
    bit ok;
    @(negedge clk) ped_ns_req = 1'b1;
    @(negedge clk) ped_ns_req = 1'b0;
    #2 start = 1'b0;
    #1;
    total++;
    if (snap() !== mk(0, 15, 2'b00) || tick !== 1'b0)
      $display("[TB] FAIL reset_async: got %h tick %b required %h tick 0",
               snap(), tick, mk(0, 15, 2'b00));
    else passed++;
    @(negedge clk) start = 1'b1;
    push(0, 14, 1, 2'b00); push(1, 3, 1, 2'b00); push(2, 1, 1, 2'b00); push(3, 15, 15, 2'b00);
    while (exp_q.size() > 0) begin
      next_tick(got, n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || got !== e) $display("[TB] FAIL reset_latch_clear: got %h required %h", got, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_hold();
`ifdef PED_REQ_EN
    test_ped();
`else
    test_ped_ignored();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
